// File: rtl/oclib_bc_to_word_if.sv
// ---------------------------------------------------------------------------
// oclib_bc_to_word_if
// Bundles the two handshakes of the byte-to-word deserializer:
//   byte channel in : bc_data[7:0], bc_valid  -> deserializer
//                     bc_ready                <- deserializer
//   word out        : word_data[WordWidth-1:0], word_valid <- deserializer
//                     word_ready                           -> deserializer
// Modports:
//   slave  : the deserializer's view (consumes bytes, produces words)
//   master : the surrounding logic's view (produces bytes, consumes words)
// ---------------------------------------------------------------------------
interface oclib_bc_to_word_if #(
    parameter int WordWidth = 64
);
    logic [7:0]           bc_data;
    logic                 bc_valid;
    logic                 bc_ready;
    logic [WordWidth-1:0] word_data;
    logic                 word_valid;
    logic                 word_ready;

    modport slave (
        input  bc_data,
        input  bc_valid,
        input  word_ready,
        output bc_ready,
        output word_data,
        output word_valid
    );

    modport master (
        output bc_data,
        output bc_valid,
        output word_ready,
        input  bc_ready,
        input  word_data,
        input  word_valid
    );
endinterface

// File: rtl/oclib_bc_to_word.sv
// ---------------------------------------------------------------------------
// oclib_bc_to_word
// Reassembles fixed-width words from an 8-bit byte channel. Frames are
// optionally prefixed by a length byte equal to WordBytes+1; data bytes
// arrive MSB-first. Completed words are held on a valid/ready output until
// accepted; no new byte is taken while a word is held.
//
// Ports:
//   clock_i          clock
//   reset_ni         synchronous reset, active low
//   bus_io           slave side of oclib_bc_to_word_if (byte in, word out)
//   length_error_o   one-cycle pulse: length byte was not WordBytes+1
//   timeout_error_o  one-cycle pulse: frame aborted after TimeoutCycles idle
// ---------------------------------------------------------------------------
module oclib_bc_to_word #(
    parameter int WordWidth     = 64,
    parameter bit PrefixLength  = 1'b1,
    parameter int TimeoutCycles = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    oclib_bc_to_word_if.slave    bus_io,
    output logic                 length_error_o,
    output logic                 timeout_error_o
);

    localparam int WordBytes = (WordWidth + 7) / 8;
    localparam int AsmWidth  = WordBytes * 8;
    localparam int CntW      = (WordBytes > 1) ? $clog2(WordBytes) : 1;
    localparam int TmoW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit TmoEn     = (TimeoutCycles > 0);

    localparam logic [CntW-1:0] CntLast = CntW'(WordBytes - 1);
    localparam logic [7:0]      LenGood = 8'(WordBytes + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    localparam logic [1:0] ST_LENGTH  = 2'd0;
    localparam logic [1:0] ST_DATA    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;
    // Where every frame (re)starts: at the length byte, or straight at data.
    localparam logic [1:0] ST_START   = PrefixLength ? ST_LENGTH : ST_DATA;

    logic [1:0]           state_q, state_d;
    logic [AsmWidth-1:0]  asm_q, asm_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [7:0]           disc_q, disc_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [WordWidth-1:0] word_data_q, word_data_d;
    logic                 word_valid_q, word_valid_d;
    logic                 ready_q, ready_d;
    logic                 len_err_q, len_err_d;
    logic                 tmo_err_q, tmo_err_d;

    logic                 byte_accept;
    logic                 tmo_run;
    logic [AsmWidth-1:0]  asm_shift;

    assign byte_accept = bus_io.bc_valid && ready_q;

    // New byte enters at the bottom; older bytes move toward the MSBs.
    generate
        if (WordBytes > 1) begin : g_shift_multi
            assign asm_shift = {asm_q[AsmWidth-9:0], bus_io.bc_data};
        end else begin : g_shift_single
            assign asm_shift = bus_io.bc_data;
        end
    endgenerate

    // The oldest byte falls off the shift and pad MSBs of byte 0 are never
    // presented; both are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{asm_q, asm_shift};

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        disc_d       = disc_q;
        tmo_d        = tmo_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        len_err_d    = 1'b0;
        tmo_err_d    = 1'b0;
        tmo_run      = 1'b0;

        case (state_q)
            ST_LENGTH: begin
                if (byte_accept) begin
                    if (bus_io.bc_data == LenGood) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        len_err_d = 1'b1;
                        // A length of 0 or 1 carries no payload to skip.
                        if (bus_io.bc_data > 8'd1) begin
                            disc_d  = bus_io.bc_data - 8'd1;
                            state_d = ST_DISCARD;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                tmo_run = 1'b1;
                if (byte_accept) begin
                    disc_d = disc_q - 8'd1;
                    if (disc_q == 8'd1) begin
                        state_d = ST_LENGTH;
                    end
                end
            end
            ST_DATA: begin
                // Idle before the first data byte is not mid-frame.
                tmo_run = (cnt_q != '0);
                if (byte_accept) begin
                    asm_d = asm_shift;
                    if (cnt_q == CntLast) begin
                        word_data_d  = asm_shift[WordWidth-1:0];
                        word_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin // ST_HOLD
                if (word_valid_q && bus_io.word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = ST_START;
                end
            end
        endcase

        // Idle-cycle watchdog; an accepted byte always wins over expiry.
        if (byte_accept || !tmo_run || !TmoEn) begin
            tmo_d = '0;
        end else if (tmo_q == TmoLast) begin
            tmo_d     = '0;
            tmo_err_d = 1'b1;
            state_d   = ST_START;
            cnt_d     = '0;
            disc_d    = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        ready_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= ST_START;
            asm_q        <= '0;
            cnt_q        <= '0;
            disc_q       <= '0;
            tmo_q        <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            len_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            disc_q       <= disc_d;
            tmo_q        <= tmo_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            ready_q      <= ready_d;
            len_err_q    <= len_err_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign bus_io.bc_ready   = ready_q;
    assign bus_io.word_data  = word_data_q;
    assign bus_io.word_valid = word_valid_q;
    assign length_error_o    = len_err_q;
    assign timeout_error_o   = tmo_err_q;

endmodule

// File: tb/tb_oclib_bc_to_word.sv
// ---------------------------------------------------------------------------
// tb_oclib_bc_to_word
// Directed bench for oclib_bc_to_word with three instances:
//   A: 64-bit words, length prefix, 8-cycle timeout
//   B: 12-bit words, length prefix, no timeout
//   C: 12-bit words, no prefix, no timeout
// ---------------------------------------------------------------------------
module tb_oclib_bc_to_word;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    oclib_bc_to_word_if #(.WordWidth(64)) ifa ();
    oclib_bc_to_word_if #(.WordWidth(12)) ifb ();
    oclib_bc_to_word_if #(.WordWidth(12)) ifc ();

    logic len_err_a, tmo_err_a, len_err_b, tmo_err_b, len_err_c, tmo_err_c;

    oclib_bc_to_word #(.WordWidth(64), .PrefixLength(1'b1), .TimeoutCycles(8)) dut_a (
        .clock_i(clk), .reset_ni(reset_n), .bus_io(ifa.slave),
        .length_error_o(len_err_a), .timeout_error_o(tmo_err_a)
    );
    oclib_bc_to_word #(.WordWidth(12), .PrefixLength(1'b1), .TimeoutCycles(0)) dut_b (
        .clock_i(clk), .reset_ni(reset_n), .bus_io(ifb.slave),
        .length_error_o(len_err_b), .timeout_error_o(tmo_err_b)
    );
    oclib_bc_to_word #(.WordWidth(12), .PrefixLength(1'b0), .TimeoutCycles(0)) dut_c (
        .clock_i(clk), .reset_ni(reset_n), .bus_io(ifc.slave),
        .length_error_o(len_err_c), .timeout_error_o(tmo_err_c)
    );

    int checks   = 0;
    int failures = 0;
    int a_err_cnt = 0;

    always @(negedge clk) begin
        if (len_err_a || tmo_err_a) a_err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        case (which)
            0: begin ifa.bc_valid = v; ifa.bc_data = d; end
            1: begin ifb.bc_valid = v; ifb.bc_data = d; end
            default: begin ifc.bc_valid = v; ifc.bc_data = d; end
        endcase
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0: return ifa.bc_ready;
            1: return ifb.bc_ready;
            default: return ifc.bc_ready;
        endcase
    endfunction

    // Present one byte; returns #1 after the edge that accepted it.
    task automatic send(input int which, input logic [7:0] d);
        int n;
        @(negedge clk);
        drive(which, 1'b1, d);
        n = 0;
        while (!rdy(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(which)) check_eq("send_stall", {63'd0, rdy(which)}, 64'd1);
        @(posedge clk);
        #1;
        drive(which, 1'b0, 8'h00);
    endtask

    task automatic send_w64(input logic [63:0] w);
        send(0, 8'h09);
        for (int k = 0; k < 8; k++) begin
            send(0, w[63-8*k -: 8]);
        end
    endtask

    task automatic check_word_a(input string tag, input logic [63:0] exp);
        check_eq({tag, "_valid"}, {63'd0, ifa.word_valid}, 64'd1);
        check_eq({tag, "_data"}, ifa.word_data, exp);
        $display("word %s data=%h", tag, ifa.word_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int err_snap;
        reset_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        ifa.word_ready = 1'b1;
        ifb.word_ready = 1'b1;
        ifc.word_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, ifa.word_valid}, 64'd0);
        check_eq("rst_data", ifa.word_data, 64'd0);
        check_eq("rst_ready", {63'd0, ifa.bc_ready}, 64'd0);
        check_eq("rst_lenerr", {63'd0, len_err_a}, 64'd0);
        check_eq("rst_tmoerr", {63'd0, tmo_err_a}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rel_ready_early", {63'd0, ifa.bc_ready}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("rel_ready", {63'd0, ifa.bc_ready}, 64'd1);

        // Basic frame, consumer always ready
        send(0, 8'h09);
        for (int k = 1; k <= 8; k++) begin
            send(0, 8'(k));
            if (k < 8) check_eq("basic_early_valid", {63'd0, ifa.word_valid}, 64'd0);
        end
        check_word_a("basic", 64'h0102030405060708);
        check_eq("basic_ready_hold", {63'd0, ifa.bc_ready}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("basic_valid_drop", {63'd0, ifa.word_valid}, 64'd0);
        check_eq("basic_ready_back", {63'd0, ifa.bc_ready}, 64'd1);

        // Backpressure: word held for 10 cycles, next length byte waits
        ifa.word_ready = 1'b0;
        send_w64(64'hA1A2A3A4A5A6A7A8);
        check_word_a("hold", 64'hA1A2A3A4A5A6A7A8);
        @(negedge clk);
        drive(0, 1'b1, 8'h09);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", {63'd0, ifa.word_valid}, 64'd1);
            check_eq("hold_data", ifa.word_data, 64'hA1A2A3A4A5A6A7A8);
            check_eq("hold_ready", {63'd0, ifa.bc_ready}, 64'd0);
        end
        @(negedge clk);
        ifa.word_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hs_valid", {63'd0, ifa.word_valid}, 64'd0);
        check_eq("hs_ready", {63'd0, ifa.bc_ready}, 64'd1);
        send(0, 8'h09);
        for (int k = 0; k < 8; k++) send(0, 8'hB1 + 8'(k));
        check_word_a("after_hold", 64'hB1B2B3B4B5B6B7B8);

        // Bad length: discard payload, then a length of 1 stays at length
        send(0, 8'h03);
        check_eq("len3_err", {63'd0, len_err_a}, 64'd1);
        send(0, 8'hAA);
        check_eq("discard_aa_err", {63'd0, len_err_a}, 64'd0);
        send(0, 8'hBB);
        check_eq("discard_bb_err", {63'd0, len_err_a}, 64'd0);
        send(0, 8'h01);
        check_eq("len1_err", {63'd0, len_err_a}, 64'd1);
        send_w64(64'h1112131415161718);
        check_word_a("after_lenerr", 64'h1112131415161718);

        // Timeout after 8 idle cycles mid-frame
        send(0, 8'h09);
        send(0, 8'h11);
        send(0, 8'h22);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check_eq("tmo_pulse", {63'd0, tmo_err_a}, (i == 8) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1;
        check_eq("tmo_pulse_end", {63'd0, tmo_err_a}, 64'd0);
        send_w64(64'h3132333435363738);
        check_word_a("after_tmo", 64'h3132333435363738);

        // Byte arriving on the expiry cycle wins
        send(0, 8'h09);
        send(0, 8'h11);
        repeat (7) @(posedge clk);
        send(0, 8'h22);
        check_eq("tmo_race_err", {63'd0, tmo_err_a}, 64'd0);
        for (int k = 0; k < 6; k++) send(0, 8'h33 + 8'(k) * 8'h11);
        check_word_a("tmo_race", 64'h1122334455667788);

        // Reset mid-frame
        @(posedge clk);
        send(0, 8'h09);
        for (int k = 0; k < 4; k++) send(0, 8'hC1 + 8'(k));
        err_snap = a_err_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mrst_valid", {63'd0, ifa.word_valid}, 64'd0);
        check_eq("mrst_data", ifa.word_data, 64'd0);
        check_eq("mrst_ready", {63'd0, ifa.bc_ready}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send_w64(64'hD1D2D3D4D5D6D7D8);
        check_word_a("after_mrst", 64'hD1D2D3D4D5D6D7D8);
        check_eq("mrst_no_err", 64'(a_err_cnt), 64'(err_snap));

        // 12-bit words with prefix
        send(1, 8'h09);
        check_eq("b_len_err", {63'd0, len_err_b}, 64'd1);
        repeat (8) send(1, 8'h55);
        send(1, 8'h03);
        send(1, 8'h0A);
        send(1, 8'hBC);
        check_eq("b_valid", {63'd0, ifb.word_valid}, 64'd1);
        check_eq("b_data", 64'(ifb.word_data), 64'h0ABC);
        $display("word b data=%h", ifb.word_data);

        // 12-bit words without prefix, including dropped pad bits
        send(2, 8'h0A);
        send(2, 8'hBC);
        check_eq("c_valid", {63'd0, ifc.word_valid}, 64'd1);
        check_eq("c_data", 64'(ifc.word_data), 64'h0ABC);
        $display("word c data=%h", ifc.word_data);
        send(2, 8'hFF);
        send(2, 8'h12);
        check_eq("c_pad_data", 64'(ifc.word_data), 64'h0F12);
        check_eq("c_lenerr", {63'd0, len_err_c}, 64'd0);
        $display("word c data=%h", ifc.word_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
